// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver with scancode-set-2 decoding to menu key codes.
// Glitch-filtered clock, odd-parity frame check, break/extended prefix handling.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] KEY_NONE = 4'h0;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic          clk_s1, clk_s2;
    logic          dat_s1, dat_s2;
    logic          filt, filt_d;
    logic [FW-1:0] flt_cnt;
    logic          fall, any_edge;

    state_t        state;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] tmo;
    logic          byte_ok;
    logic [7:0]    rx_byte;

    logic          brk, ext;
    logic [3:0]    code;

    // Two-flop synchronisers for both asynchronous pins
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Glitch filter: level follows the pin only after a full run of equal samples
    always_ff @(posedge clk) begin
        if (rst) begin
            filt    <= 1'b1;
            filt_d  <= 1'b1;
            flt_cnt <= '0;
        end else begin
            filt_d <= filt;
            if (clk_s2 == filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_MAX) begin
                filt    <= clk_s2;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    assign fall     = filt_d & ~filt;
    assign any_edge = filt_d ^ filt;

    // Frame receiver with parity/stop check and inactivity timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            tmo       <= '0;
            byte_ok   <= 1'b0;
            rx_byte   <= '0;
            frame_err <= 1'b0;
        end else begin
            byte_ok   <= 1'b0;
            frame_err <= 1'b0;
            if (fall) begin
                unique case (state)
                    IDLE: begin
                        if (!dat_s2) begin
                            state   <= DATA;
                            bit_cnt <= 4'd1;
                        end
                    end
                    DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'd8) state <= PARITY;
                    end
                    PARITY: begin
                        par     <= dat_s2;
                        bit_cnt <= bit_cnt + 1'b1;
                        state   <= STOP;
                    end
                    STOP: begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        if (dat_s2 && (^{shreg, par})) begin
                            byte_ok <= 1'b1;
                            rx_byte <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                endcase
            end
            if (any_edge) begin
                tmo <= '0;
            end else if (state != IDLE) begin
                if (tmo == TMO_MAX) begin
                    state     <= IDLE;
                    bit_cnt   <= '0;
                    tmo       <= '0;
                    frame_err <= 1'b1;
                end else begin
                    tmo <= tmo + 1'b1;
                end
            end else begin
                tmo <= '0;
            end
        end
    end

    // Scancode lookup; extended codes never map to a menu key
    always_comb begin
        code = KEY_NONE;
        if (!ext) begin
            case (rx_byte)
                8'h16:   code = 4'h1;
                8'h1E:   code = 4'h2;
                8'h26:   code = 4'h3;
                8'h25:   code = 4'h4;
                8'h76:   code = 4'hF;
                default: code = KEY_NONE;
            endcase
        end
    end

    // Prefix tracking and held-key update
    always_ff @(posedge clk) begin
        if (rst) begin
            key       <= KEY_NONE;
            key_valid <= 1'b0;
            brk       <= 1'b0;
            ext       <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (byte_ok) begin
                if (rx_byte == 8'hF0) begin
                    brk <= 1'b1;
                end else if (rx_byte == 8'hE0) begin
                    ext <= 1'b1;
                end else begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                    if (code != KEY_NONE) begin
                        if (brk) begin
                            if (code == key) key <= KEY_NONE;
                        end else if (code != key) begin
                            key       <= code;
                            key_valid <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomised PS/2 frame bench for ps2_key_decoder.
// Reference model tracks held key and prefix flags from scancode rules.
module tb_ps2_key_decoder;

    localparam int FLT = 8;
    localparam int TMO = 3000;
    localparam int KV_LAT = 2 + FLT + 2;
    localparam int FE_LAT = 2 + FLT + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [3:0] key;
    logic       key_valid;
    logic       frame_err;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int vcnt = 0;
    int ecnt = 0;
    int both = 0;
    int t_kv = 0;
    int t_fe = 0;
    int t_stop = 0;
    int t_rise = 0;

    logic [3:0] m_key;
    bit         m_brk;
    bit         m_ext;
    logic [3:0] map_tbl [256];

    ps2_key_decoder #(
        .FILTER_LEN    (FLT),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key      (key),
        .key_valid(key_valid),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (key_valid) begin
                vcnt = vcnt + 1;
                t_kv = cyc;
            end
            if (frame_err) begin
                ecnt = ecnt + 1;
                t_fe = cyc;
            end
            if (key_valid && frame_err) both = both + 1;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad,
                              input int nbits, input bit gl);
        logic [10:0] f;
        logic        p;
        p = ~^b;
        if (bad) p = ~p;
        f = {1'b1, p, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            tick(5);
            ps2_data = f[i];
            tick(5);
            if (gl) begin
                ps2_clk = 1'b0;
                tick(1);
                ps2_clk = 1'b1;
            end
            tick(4);
            ps2_clk = 1'b0;
            if (i == 10) t_stop = cyc;
            tick(10);
            if (gl) begin
                ps2_clk = 1'b1;
                tick(1);
                ps2_clk = 1'b0;
            end
            tick(10);
            ps2_clk = 1'b1;
            t_rise = cyc;
        end
        tick(5);
        ps2_data = 1'b1;
    endtask

    // Model: returns 1 when a key_valid pulse is expected
    function automatic bit model_byte(input logic [7:0] b);
        logic [3:0] c;
        bit         pulse;
        pulse = 1'b0;
        if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else begin
            c = m_ext ? 4'h0 : map_tbl[b];
            if (c != 4'h0 && m_brk && c == m_key) m_key = 4'h0;
            if (c != 4'h0 && !m_brk && c != m_key) begin
                m_key = c;
                pulse = 1'b1;
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
        return pulse;
    endfunction

    task automatic run_frame(input string tag, input logic [7:0] b,
                             input bit bad, input bit gl);
        bit ep;
        vcnt = 0;
        ecnt = 0;
        ep = 1'b0;
        if (!bad) ep = model_byte(b);
        send_frame(b, bad, 11, gl);
        tick(40);
        chk({tag, "_key"}, int'(key), int'(m_key));
        chk({tag, "_kv_cnt"}, vcnt, int'(ep));
        chk({tag, "_err_cnt"}, ecnt, int'(bad));
        if (ep) chk({tag, "_kv_lat"}, t_kv - t_stop, KV_LAT);
        if (bad) chk({tag, "_err_lat"}, t_fe - t_stop, FE_LAT);
    endtask

    initial begin
        logic [7:0] pool [8];
        logic [7:0] b;
        bit         bad;
        bit         gl;

        for (int i = 0; i < 256; i++) map_tbl[i] = 4'h0;
        map_tbl[8'h16] = 4'h1;
        map_tbl[8'h1E] = 4'h2;
        map_tbl[8'h26] = 4'h3;
        map_tbl[8'h25] = 4'h4;
        map_tbl[8'h76] = 4'hF;
        pool[0] = 8'h16; pool[1] = 8'h1E; pool[2] = 8'h26; pool[3] = 8'h25;
        pool[4] = 8'h76; pool[5] = 8'hF0; pool[6] = 8'hE0; pool[7] = 8'hF0;
        m_key = 4'h0;
        m_brk = 1'b0;
        m_ext = 1'b0;

        tick(5);
        chk("rst_key", int'(key), 0);
        chk("rst_kv", int'(key_valid), 0);
        chk("rst_err", int'(frame_err), 0);
        rst = 1'b0;
        tick(20);

        run_frame("t1_1e", 8'h1E, 1'b0, 1'b0);
        run_frame("t2_f0", 8'hF0, 1'b0, 1'b0);
        run_frame("t2_brk", 8'h1E, 1'b0, 1'b0);
        run_frame("t2_rep_a", 8'h1E, 1'b0, 1'b0);
        run_frame("t2_rep_b", 8'h1E, 1'b0, 1'b0);
        run_frame("t3_badpar", 8'h76, 1'b1, 1'b0);

        vcnt = 0;
        ecnt = 0;
        send_frame(8'h26, 1'b0, 5, 1'b0);
        for (int i = 0; i < TMO + 200 && ecnt == 0; i++) tick(1);
        chk("t4_tmo_err", ecnt, 1);
        chk("t4_tmo_win", int'((t_fe - t_rise >= TMO) &&
                               (t_fe - t_rise <= TMO + 20)), 1);
        chk("t4_tmo_key", int'(key), int'(m_key));
        chk("t4_tmo_kv", vcnt, 0);
        run_frame("t4_25", 8'h25, 1'b0, 1'b0);

        run_frame("t5_e0", 8'hE0, 1'b0, 1'b1);
        run_frame("t5_ext26", 8'h26, 1'b0, 1'b1);
        run_frame("t5_glitch", 8'h76, 1'b0, 1'b1);

        vcnt = 0;
        ecnt = 0;
        send_frame(8'h16, 1'b0, 6, 1'b0);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        m_key = 4'h0;
        m_brk = 1'b0;
        m_ext = 1'b0;
        tick(30);
        chk("t6_rst_key", int'(key), 0);
        chk("t6_rst_kv", vcnt, 0);
        chk("t6_rst_err", ecnt, 0);
        run_frame("t6_16", 8'h16, 1'b0, 1'b0);

        for (int n = 0; n < 28; n++) begin
            if ($urandom_range(0, 4) == 0) b = 8'($urandom);
            else b = pool[$urandom_range(0, 7)];
            bad = ($urandom_range(0, 7) == 0);
            gl = 1'($urandom_range(0, 1));
            run_frame("rnd", b, bad, gl);
        end

        chk("no_overlap", both, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
